// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA sync generator and the
// sync receiver, plus the receiver's tracking-state encoding.
package vga_timing_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_FRONT    = 16;
  localparam int H_SYNC     = 96;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 480;
  localparam int V_FRONT    = 10;
  localparam int V_SYNC     = 2;
  localparam int V_TOTAL    = 525;
  localparam int LOCK_LINES = 4;

  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int VS_START = V_ACTIVE + V_FRONT;

  // Receiver tracking states, kept as plain constants for the legacy tools.
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] H_TRACK = 2'd1;
  localparam logic [1:0] V_TRACK = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

endpackage

// File: rtl/vga_pos_predictor.sv
// Free-running h/v position predictor for the sync receiver. h and v name the
// pixel currently held in the receiver's sync input registers.
module vga_pos_predictor #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load_h,
  input  logic       load_v,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       exp_hs,
  output logic       exp_vs,
  output logic       h_wrap
);

  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  logic v_wrap;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);
  assign exp_hs = !((h >= HS_START) && (h < HS_END));
  assign exp_vs = !((v >= VS_START) && (v < VS_END));

  // Loads mean "the pixel being evaluated now sits at this position", so the
  // registered value is the position of the following pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      h <= '0;
      v <= '0;
    end else if (clear) begin
      h <= '0;
      v <= '0;
    end else if (load_h) begin
      h <= HS_START + 10'd1;
      v <= '0;
    end else begin
      h <= h_wrap ? 10'd0 : h + 10'd1;
      if (load_v)      v <= VS_START;
      else if (h_wrap) v <= v_wrap ? 10'd0 : v + 10'd1;
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: flywheel-locks to incoming hsync/vsync, rebuilds the
// pixel position and flags any deviation from the predicted sync levels.
module vga_sync_rx #(
  parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_TOTAL    = vga_timing_pkg::V_TOTAL,
  parameter int LOCK_LINES = vga_timing_pkg::LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       locked,
  output logic       frame_start,
  output logic       error,
  output logic [7:0] err_count
);

  import vga_timing_pkg::SEARCH;
  import vga_timing_pkg::H_TRACK;
  import vga_timing_pkg::V_TRACK;
  import vga_timing_pkg::LOCKED;

  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam int         LW       = $clog2(LOCK_LINES + 1);
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_LINES);

  logic          hs_r, vs_r, hs_d, vs_d;
  logic [1:0]    state, state_n;
  logic [LW-1:0] line_ok, line_ok_n;
  logic [9:0]    h, v;
  logic          exp_hs, exp_vs, h_wrap;
  logic          clear, load_h, load_v, going_locked, err_hit, lock_now;
  logic          hs_fall, vs_fall, h_mis, v_mis;

  vga_pos_predictor #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL)
  ) u_pred (
    .clk(clk), .reset(reset), .clear(clear), .load_h(load_h), .load_v(load_v),
    .h(h), .v(v), .exp_hs(exp_hs), .exp_vs(exp_vs), .h_wrap(h_wrap)
  );

  assign hs_fall  = hs_d & ~hs_r;
  assign vs_fall  = vs_d & ~vs_r;
  assign h_mis    = (hs_r != exp_hs);
  assign v_mis    = (vs_r != exp_vs);
  assign lock_now = (state == LOCKED) || going_locked;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_n      = state;
    line_ok_n    = line_ok;
    clear        = 1'b0;
    load_h       = 1'b0;
    load_v       = 1'b0;
    going_locked = 1'b0;
    err_hit      = 1'b0;
    case (state)
      SEARCH: begin
        if (hs_fall) begin
          load_h    = 1'b1;
          line_ok_n = '0;
          state_n   = H_TRACK;
        end else begin
          clear = 1'b1;
        end
      end
      H_TRACK: begin
        if (h_mis) begin
          state_n = SEARCH;
        end else begin
          if (h_wrap && line_ok != LOCK_FULL) line_ok_n = line_ok + 1'b1;
          // A vsync edge before enough clean lines is simply ignored.
          if (vs_fall && line_ok == LOCK_FULL) begin
            if (h == 10'd0) begin
              load_v  = 1'b1;
              state_n = V_TRACK;
            end else begin
              state_n = SEARCH;
            end
          end
        end
      end
      V_TRACK: begin
        if (h_mis || v_mis) begin
          state_n = SEARCH;
        end else if (h == 10'd0 && v == VS_START) begin
          going_locked = 1'b1;
          state_n      = LOCKED;
        end
      end
      default: begin
        if (h_mis || v_mis) begin
          err_hit = 1'b1;
          state_n = SEARCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      state       <= SEARCH;
      line_ok     <= '0;
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      error       <= 1'b0;
      err_count   <= '0;
    end else begin
      hs_r    <= hsync;
      vs_r    <= vsync;
      hs_d    <= hs_r;
      vs_d    <= vs_r;
      state   <= state_n;
      line_ok <= line_ok_n;
      // Status describes the pixel just evaluated, so locked stays high on
      // the mismatching pixel and drops with the next one.
      hpos        <= (state == SEARCH) ? 10'd0 : h;
      vpos        <= (state == V_TRACK || state == LOCKED) ? v : 10'd0;
      locked      <= lock_now;
      display_on  <= lock_now && (h < H_ACT) && (v < V_ACT);
      frame_start <= lock_now && (h == 10'd0) && (v == 10'd0);
      error       <= err_hit;
      if (err_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the VGA sync interface: samples an incoming hsync/vsync pair and reconstructs hpos, vpos and display_on.
- Flywheel tracker: locks to 640x480@60 timing, then checks every cycle against predicted sync levels and flags any deviation.
- Sits beside the sync generator on the pixel-clock domain as a loopback monitor and verification target; also feeds capture/overlay logic that sees only sync pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width (pixels)
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_TOTAL, 525, lines per frame
- LOCK_LINES, 4, clean lines required before vertical acquisition

Ports:
- clk  in  1  pixel clock; sync inputs are synchronous to it
- reset  in  1  asynchronous, active-low reset
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- hpos  out  10  reconstructed horizontal position
- vpos  out  10  reconstructed vertical position
- display_on  out  1  locked && hpos<H_ACTIVE && vpos<V_ACTIVE
- locked  out  1  full-frame lock achieved
- frame_start  out  1  one-cycle pulse at (0,0) while locked
- error  out  1  one-cycle pulse on timing mismatch while locked
- err_count  out  8  saturating count of error pulses

Behaviour:
- Reset (reset=0, async): state=SEARCH; hpos=0, vpos=0, display_on=0, locked=0, frame_start=0, error=0, err_count=0; sample registers =1 (idle high).
- Input register: hsync and vsync are each registered once. Edge detection runs on the registered copies.
- Latency: all outputs are registered. They describe the pixel whose sync levels were on the pins 2 clk earlier.
- Position counters: predicted h runs 0..H_TOTAL-1 and wraps to 0. Predicted v increments on h wrap and wraps V_TOTAL-1 to 0.
- Sync start points: HS_START = H_ACTIVE+H_FRONT = 656; VS_START = V_ACTIVE+V_FRONT = 490.
- Expected levels:
  - exp_hs = 0 iff HS_START <= h < HS_START+H_SYNC (656..751)
  - exp_vs = 0 iff VS_START <= v < VS_START+V_SYNC (490..491)
  - vsync changes only at h=0.
- SEARCH:
  - hpos/vpos held 0.
  - On hsync falling edge: load h=HS_START, clear line_ok, go H_TRACK.
- H_TRACK:
  - Compare registered hsync against exp_hs every cycle; mismatch -> SEARCH (no error pulse).
  - Each h wrap increments line_ok, saturating at LOCK_LINES.
  - vsync falling edge with line_ok<LOCK_LINES: ignored.
  - vsync falling edge with line_ok==LOCK_LINES and predicted h==0: load v=VS_START, go V_TRACK.
  - vsync falling edge with line_ok==LOCK_LINES and h!=0: -> SEARCH.
  - vpos output 0 in this state.
- V_TRACK:
  - Compare both syncs every cycle; any mismatch -> SEARCH.
  - On reaching (h,v)=(0,VS_START) again with no mismatch: locked=1, go LOCKED.
- LOCKED:
  - Compare both syncs every cycle.
  - On mismatch: error=1 for one cycle, err_count+1 saturating at 255, locked=0 and display_on=0 the following cycle, go SEARCH.
  - frame_start=1 on the cycle hpos=0, vpos=0.
- Simultaneous hsync and vsync mismatch in the same cycle: a single error pulse, single increment.
- err_count is cleared only by reset and holds its value across relock.
- Reset mid-frame: immediate return to the reset values; reacquisition starts from scratch.
- Width rules: hpos/vpos are 10-bit unsigned. Comparisons are unsigned. No arithmetic overflow is possible with the default parameters.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the H_/V_ timing constants, also used by the existing sync generator;
  - derived HS_START and VS_START;
  - the state enum SEARCH/H_TRACK/V_TRACK/LOCKED.
- One natural sub-module: vga_pos_predictor. It is the free-running h/v counter with load-h, load-v and clear inputs, and emits exp_hs, exp_vs and wrap flags. The FSM, edge detect, error and status logic stay in vga_sync_rx.

Test Plan:
- Clean stream from the sync generator with both blocks reset together:
  - first vsync fall at input cycle 392000; locked rises at cycle 812000+2;
  - thereafter hpos/vpos equal the generator's with 2-cycle lag;
  - frame_start every 420000 cycles;
  - error never asserts.
- Locked, one hsync pulse lengthened to 97 clocks: error pulses once on the first mismatching cycle (+2 latency), err_count=1, locked drops, then relock after the next full clean frame.
- Locked, vsync pulse at line 491 instead of 490: single error, err_count=1, state SEARCH.
- vsync falls after only 3 clean lines from SEARCH: ignored, no lock. The next vsync, one frame later, is accepted and locked rises one frame after that.
- 300 injected errors (relock between each): err_count saturates at 255.
- reset=0 asserted mid-frame while locked: all outputs 0 within the same cycle (async). After release, locked stays 0 until a full reacquisition completes.
